// File: rtl/cm_sort_pkg.sv
// cm_sort_pkg: shared helpers for the cm_sort pipelined sorter
// sclog2(n): ceil(log2(n)) with a minimum of 1, used to size index fields
package cm_sort_pkg;
  function automatic int sclog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cm_sort_rank.sv
// cm_sort_rank: output slot of element POS within a DCNT-word vector
// d_i    : full input vector, element k is word k
// rank_o : slot of word POS; ties are broken by input position (stable)
// CM_SORT_DESC_EN: when defined, rank counts larger words (descending order)
module cm_sort_rank
  import cm_sort_pkg::*;
#(
  parameter int DCNT   = 8,
  parameter int DWIDTH = 16,
  parameter int POS    = 0
) (
  input  logic [DCNT-1:0][DWIDTH-1:0]   d_i,
  output logic [sclog2(DCNT)-1:0]       rank_o
);
  localparam int IW = sclog2(DCNT);
  logic [IW:0] cnt;
  always_comb begin
    cnt = '0;
    for (int j = 0; j < DCNT; j++)
`ifdef CM_SORT_DESC_EN
      if (d_i[j] > d_i[POS] || (j < POS && d_i[j] == d_i[POS])) cnt = cnt + (IW+1)'(1);
`else
      if (d_i[j] < d_i[POS] || (j < POS && d_i[j] == d_i[POS])) cnt = cnt + (IW+1)'(1);
`endif
  end
  // ranks never exceed DCNT-1, so dropping the carry bit is lossless
  assign rank_o = IW'(cnt);
endmodule

// File: rtl/cm_sort.sv
// cm_sort: streaming stable sorter, one DCNT-word vector per cycle, latency REG_CNT
// i_clk/i_rst : rising-edge clock, asynchronous active-high reset
// i_vld/i_data: input vector valid and words (element k = word k)
// o_vld       : one-cycle pulse per accepted vector
// o_data/o_idx: sorted words (slot 0 smallest) and their input positions, held while o_vld=0
// CM_SORT_DESC_EN: when defined, slot 0 holds the largest word
module cm_sort
  import cm_sort_pkg::*;
#(
  parameter int DCNT    = 8,
  parameter int DWIDTH  = 16,
  parameter int REG_CNT = 1,
  localparam int IDX_WIDTH = sclog2(DCNT)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_vld,
  input  logic [DCNT-1:0][DWIDTH-1:0]        i_data,
  output logic                               o_vld,
  output logic [DCNT-1:0][IDX_WIDTH-1:0]     o_idx,
  output logic [DCNT-1:0][DWIDTH-1:0]        o_data
);
  // one register stage ahead of the scatter when REG_CNT>1, the rest after it
  localparam int POST = (REG_CNT > 1) ? REG_CNT - 1 : 1;
  logic [DCNT-1:0][IDX_WIDTH-1:0] rank_w, rank_s, idx_d;
  logic [DCNT-1:0][DWIDTH-1:0]    data_s, sort_d;
  logic                           vld_s;
  for (genvar g = 0; g < DCNT; g++) begin : g_rank
    cm_sort_rank #(.DCNT(DCNT), .DWIDTH(DWIDTH), .POS(g)) u_rank (
      .d_i    (i_data),
      .rank_o (rank_w[g])
    );
  end
  if (REG_CNT > 1) begin : g_pre
    logic [DCNT-1:0][DWIDTH-1:0]    data_q;
    logic [DCNT-1:0][IDX_WIDTH-1:0] rank_q;
    logic                           vld_q;
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        rank_q <= '0;
      end else begin
        vld_q <= i_vld;
        if (i_vld) begin
          data_q <= i_data;
          rank_q <= rank_w;
        end
      end
    assign data_s = data_q;
    assign rank_s = rank_q;
    assign vld_s  = vld_q;
  end else begin : g_nopre
    assign data_s = i_data;
    assign rank_s = rank_w;
    assign vld_s  = i_vld;
  end
  // ranks form a permutation, so every slot is written exactly once
  always_comb begin
    sort_d = '0;
    idx_d  = '0;
    for (int i = 0; i < DCNT; i++) begin
      sort_d[rank_s[i]] = data_s[i];
      idx_d[rank_s[i]]  = IDX_WIDTH'(i);
    end
  end
  for (genvar p = 0; p < POST; p++) begin : g_post
    logic                           vld_d, vld_q;
    logic [DCNT-1:0][DWIDTH-1:0]    data_d, data_q;
    logic [DCNT-1:0][IDX_WIDTH-1:0] idx_dd, idx_q;
    if (p == 0) begin : g_head
      assign vld_d  = vld_s;
      assign data_d = sort_d;
      assign idx_dd = idx_d;
    end else begin : g_tail
      assign vld_d  = g_post[p-1].vld_q;
      assign data_d = g_post[p-1].data_q;
      assign idx_dd = g_post[p-1].idx_q;
    end
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        idx_q  <= '0;
      end else begin
        vld_q <= vld_d;
        if (vld_d) begin
          data_q <= data_d;
          idx_q  <= idx_dd;
        end
      end
  end
  assign o_vld  = g_post[POST-1].vld_q;
  assign o_data = g_post[POST-1].data_q;
  assign o_idx  = g_post[POST-1].idx_q;
endmodule

// File: tb/tb_cm_sort.sv
// tb_cm_sort: scoreboard bench for cm_sort over four DCNT/REG_CNT configurations
module tb_cm_sort;
  localparam int NC [4] = '{4, 6, 10, 8};
  localparam int RC [4] = '{1, 2, 4, 3};

  typedef struct packed {
    logic [31:0]      due;
    logic [9:0][15:0] src;
    logic [9:0][15:0] d;
    logic [9:0][3:0]  i;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]       iv = '0;
  logic [9:0][15:0] in_d [4];
  logic [3:0]       ov;
  logic [9:0][15:0] od [4];
  logic [9:0][3:0]  oi [4];

  logic [3:0][15:0] o0d; logic [3:0][1:0] o0i;
  logic [5:0][15:0] o1d; logic [5:0][2:0] o1i;
  logic [9:0][15:0] o2d; logic [9:0][3:0] o2i;
  logic [7:0][15:0] o3d; logic [7:0][2:0] o3i;

  exp_t sb [4][$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cm_sort #(.DCNT(4),  .DWIDTH(16), .REG_CNT(1)) u0 (.i_clk(clk), .i_rst(rst), .i_vld(iv[0]),
    .i_data(in_d[0][3:0]), .o_vld(ov[0]), .o_idx(o0i), .o_data(o0d));
  cm_sort #(.DCNT(6),  .DWIDTH(16), .REG_CNT(2)) u1 (.i_clk(clk), .i_rst(rst), .i_vld(iv[1]),
    .i_data(in_d[1][5:0]), .o_vld(ov[1]), .o_idx(o1i), .o_data(o1d));
  cm_sort #(.DCNT(10), .DWIDTH(16), .REG_CNT(4)) u2 (.i_clk(clk), .i_rst(rst), .i_vld(iv[2]),
    .i_data(in_d[2][9:0]), .o_vld(ov[2]), .o_idx(o2i), .o_data(o2d));
  cm_sort #(.DCNT(8),  .DWIDTH(16), .REG_CNT(3)) u3 (.i_clk(clk), .i_rst(rst), .i_vld(iv[3]),
    .i_data(in_d[3][7:0]), .o_vld(ov[3]), .o_idx(o3i), .o_data(o3d));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      od[k] = '0;
      oi[k] = '0;
    end
    for (int j = 0; j < 4; j++)  begin od[0][j] = o0d[j]; oi[0][j] = 4'(o0i[j]); end
    for (int j = 0; j < 6; j++)  begin od[1][j] = o1d[j]; oi[1][j] = 4'(o1i[j]); end
    for (int j = 0; j < 10; j++) begin od[2][j] = o2d[j]; oi[2][j] = o2i[j];     end
    for (int j = 0; j < 8; j++)  begin od[3][j] = o3d[j]; oi[3][j] = 4'(o3i[j]); end
  end

  // reference: stable bubble sort, swapping only strictly out-of-order neighbours
  function automatic exp_t model(input int n, input logic [9:0][15:0] v, input int due);
    exp_t r;
    logic [15:0] t;
    logic [3:0]  ti;
    r = '0;
    r.due = 32'(due);
    r.src = v;
    for (int j = 0; j < n; j++) begin
      r.d[j] = v[j];
      r.i[j] = 4'(j);
    end
    for (int a = 0; a < n - 1; a++)
      for (int b = 0; b < n - 1 - a; b++)
`ifdef CM_SORT_DESC_EN
        if (r.d[b] < r.d[b+1]) begin
`else
        if (r.d[b] > r.d[b+1]) begin
`endif
          t = r.d[b]; r.d[b] = r.d[b+1]; r.d[b+1] = t;
          ti = r.i[b]; r.i[b] = r.i[b+1]; r.i[b+1] = ti;
        end
    return r;
  endfunction

  // call just after a rising edge; the vector is captured on the next edge
  task automatic send(input int k, input logic [9:0][15:0] v);
    iv[k] = 1'b1;
    in_d[k] = v;
    sb[k].push_back(model(NC[k], v, cyc + RC[k]));
  endtask

  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < 4; k++)
        if (ov[k]) begin
          checks++;
          if (sb[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld dut%0d: o_vld=1 at cycle %0d, required no pending vector", k, cyc);
          end else begin
            e = sb[k].pop_front();
            if (32'(cyc) !== e.due) begin
              errors++;
              $display("FAIL latency dut%0d: output at cycle %0d, required %0d", k, cyc, e.due);
            end
            checks++;
            if (od[k] !== e.d) begin
              errors++;
              $display("FAIL o_data dut%0d: got %h required %h", k, od[k], e.d);
            end
            checks++;
            if (oi[k] !== e.i) begin
              errors++;
              $display("FAIL o_idx dut%0d: got %h required %h", k, oi[k], e.i);
            end
            checks++;
            for (int j = 0; j < NC[k]; j++)
              if (od[k][j] !== e.src[oi[k][j]]) begin
                errors++;
                $display("FAIL src_match dut%0d slot %0d: o_data=%h input[o_idx=%0d] required equal", k, j, od[k][j], oi[k][j]);
                break;
              end
          end
        end

  task automatic test_reset();
    #1 rst = 1'b1;
    iv = 4'hF;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 10; j++) in_d[k][j] = 16'($urandom);
    for (int t = 0; t < 3; t++) begin
      if (t == 2) begin
        @(posedge clk); #1;
        rst = 1'b0;
        iv = '0;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ov[k] !== 1'b0 || od[k] !== '0 || oi[k] !== '0) begin
          errors++;
          $display("FAIL reset dut%0d t%0d: o_vld=%b o_data=%h o_idx=%h, required all zero", k, t, ov[k], od[k], oi[k]);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [9:0][15:0] v, xd;
    logic [9:0][3:0]  xi;
    v = '0; xd = '0; xi = '0;
    v[0] = 30; v[1] = 10; v[2] = 40; v[3] = 20;
`ifdef CM_SORT_DESC_EN
    xd[0] = 40; xd[1] = 30; xd[2] = 20; xd[3] = 10;
    xi[0] = 2;  xi[1] = 0;  xi[2] = 3;  xi[3] = 1;
`else
    xd[0] = 10; xd[1] = 20; xd[2] = 30; xd[3] = 40;
    xi[0] = 1;  xi[1] = 3;  xi[2] = 0;  xi[3] = 2;
`endif
    @(posedge clk); #1;
    send(0, v);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== xd || oi[0] !== xi) begin
      errors++;
      $display("FAIL basic: o_vld=%b o_data=%h o_idx=%h, required 1 %h %h", ov[0], od[0], oi[0], xd, xi);
    end
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0 || od[0] !== xd || oi[0] !== xi) begin
      errors++;
      $display("FAIL basic_hold: o_vld=%b o_data=%h o_idx=%h, required 0 %h %h", ov[0], od[0], oi[0], xd, xi);
    end
  endtask

  task automatic test_dups();
    logic [9:0][15:0] v, xd;
    logic [9:0][3:0]  xi;
    v = '0; xd = '0; xi = '0;
    v[0] = 16'hFFFF; v[1] = 5; v[2] = 16'hFFFF; v[3] = 7; v[4] = 16'hFFFF; v[5] = 1;
`ifdef CM_SORT_DESC_EN
    xd[0] = 16'hFFFF; xd[1] = 16'hFFFF; xd[2] = 16'hFFFF; xd[3] = 7; xd[4] = 5; xd[5] = 1;
    xi[0] = 0; xi[1] = 2; xi[2] = 4; xi[3] = 3; xi[4] = 1; xi[5] = 5;
`else
    xd[0] = 1; xd[1] = 5; xd[2] = 7; xd[3] = 16'hFFFF; xd[4] = 16'hFFFF; xd[5] = 16'hFFFF;
    xi[0] = 5; xi[1] = 1; xi[2] = 3; xi[3] = 0; xi[4] = 2; xi[5] = 4;
`endif
    @(posedge clk); #1;
    send(1, v);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL dups_early: o_vld=%b one cycle after capture, required 0", ov[1]);
    end
    @(negedge clk);
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== xd || oi[1] !== xi) begin
      errors++;
      $display("FAIL dups: o_vld=%b o_data=%h o_idx=%h, required 1 %h %h", ov[1], od[1], oi[1], xd, xi);
    end
  endtask

  task automatic test_equal();
    logic [9:0][15:0] v;
    logic [9:0][3:0]  xi;
    v = '0; xi = '0;
    for (int j = 0; j < 8; j++) begin
      v[j] = 16'h1234;
      xi[j] = 4'(j);
    end
    @(posedge clk); #1;
    send(3, v);
    @(posedge clk); #1;
    iv[3] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ov[3] !== 1'b1 || oi[3] !== xi) begin
      errors++;
      $display("FAIL all_equal: o_vld=%b o_idx=%h, required 1 %h", ov[3], oi[3], xi);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0][15:0] a, b;
    int c0, hi, first;
    for (int j = 0; j < 10; j++) begin
      a[j] = 16'($urandom);
      b[j] = 16'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    c0 = cyc;
    send(2, a);
    @(posedge clk); #1;
    send(2, b);
    @(posedge clk); #1;
    iv[2] = 1'b0;
    hi = 0;
    first = -1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (ov[2]) begin
        hi++;
        if (first < 0) first = cyc;
      end
    end
    checks++;
    if (hi !== 2 || first !== c0 + 4) begin
      errors++;
      $display("FAIL back_to_back: o_vld high %0d cycles from cycle %0d, required 2 from %0d", hi, first, c0 + 4);
    end
  endtask

  task automatic test_reset_flush();
    int hi;
    @(posedge clk); #1;
    iv[3] = 1'b1;
    for (int j = 0; j < 10; j++) in_d[3][j] = 16'($urandom);
    @(posedge clk); #1;
    iv[3] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hi = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (ov[3] || od[3] !== '0 || oi[3] !== '0) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL reset_flush: %0d cycles with o_vld or outputs nonzero, required 0", hi);
    end
  endtask

  task automatic test_random();
    logic [9:0][15:0] v;
    int sent;
    bit dup;
    for (int k = 0; k < 4; k++) begin
      sent = 0;
      while (sent < 1000) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 3) != 0) begin
          dup = $urandom_range(0, 1) == 1;
          v = '0;
          for (int j = 0; j < NC[k]; j++) v[j] = dup ? 16'($urandom_range(0, 3)) : 16'($urandom);
          send(k, v);
          sent++;
        end else begin
          iv[k] = 1'b0;
          in_d[k] = {10{16'hDEAD}};
        end
      end
      @(posedge clk); #1;
      iv[k] = 1'b0;
      repeat (RC[k] + 3) @(negedge clk);
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: %0d vectors without output, required 0", k, sb[k].size());
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) in_d[k] = '0;
    test_reset();
    test_basic();
    test_dups();
    test_equal();
    test_back_to_back();
    repeat (6) @(negedge clk);
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cm_sort.md
Name: cm_sort

Overview:
- Pipelined, fully combinational-per-stage sorter for one vector of DCNT unsigned DWIDTH-bit words.
- Outputs the words in ascending order, plus for each output slot the input position the word came from.
- Lives in the common-modules (cm_) library.
- Streaming: accepts a new vector every cycle, no backpressure, fixed latency of REG_CNT cycles.

Parameters:
- DCNT, 8, number of words per vector; must be ≥2.
- DWIDTH, 16, width of each word (unsigned), ≥1.
- REG_CNT, 1, pipeline register stages, equal to latency in cycles; must be ≥1.
- IDX_WIDTH, sclog2(DCNT), derived localparam, not overridable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_vld  in  1  i_data valid this cycle.
- i_data  in  DCNT x DWIDTH  packed array; element k is the input word k.
- o_vld  out  1  o_idx/o_data valid; single-cycle pulse per accepted vector.
- o_idx  out  DCNT x IDX_WIDTH  o_idx[k] is the input index of the word placed at o_data[k].
- o_data  out  DCNT x DWIDTH  sorted words; o_data[0] is the smallest.

Behaviour:
- Single clock i_clk; reset i_rst is asynchronous, active-high.
- Reset values:
  - o_vld=0, o_idx=0, o_data=0.
  - All internal valid bits are 0; internal data registers are 0.
- Rank computation, per element i:
  - rank_i = count of j with d[j]<d[i], plus count of j<i with d[j]==d[i].
  - Ranks are therefore a permutation of 0..DCNT-1.
  - The sort is stable: equal words keep their input order.
- Scatter: o_data[rank_i]=d[i] and o_idx[rank_i]=i.
- Comparisons are unsigned, full DWIDTH; no arithmetic widening is needed.
- Rank counters are IDX_WIDTH+1 bits internally and truncated to IDX_WIDTH.
- Pipeline structure:
  - REG_CNT=1: rank and scatter are combinational from i_data, and the output register captures the result.
  - REG_CNT≥2: stage 1 registers data, ranks and valid; scatter follows; the remaining REG_CNT-1 stages are a delay line ending in the output registers.
- Latency: i_vld sampled high at edge N gives o_vld=1 and the result after edge N+REG_CNT−1, i.e. visible for the cycle following edge N+REG_CNT−1 (REG_CNT edges including the capture edge).
- Throughput: one vector per cycle; back-to-back i_vld gives back-to-back o_vld.
- Data registers load only when their stage valid is 1.
- o_data/o_idx hold the last valid result while o_vld=0.
- Each stage's valid bit is copied every cycle.
- i_data is ignored when i_vld=0.
- A reset mid-operation discards every in-flight vector; no o_vld follows for them.
- All-equal inputs give o_idx = 0,1,…,DCNT-1.

Optional Feature:
- Macro: CM_SORT_DESC_EN.
- Defined: ordering is descending (o_data[0] is the largest).
  - rank_i counts j with d[j]>d[i], plus j<i with d[j]==d[i]; still stable.
- Undefined: ascending as specified above.
- Ports, latency and reset behaviour are identical in both modes.

Decomposition:
- sys_pkg_type: u8/u32/i32 types.
- cm_pkg: sclog2 (ceil-log2, minimum 1) used for IDX_WIDTH.
- No new package types are required; the index and data vectors are declared locally as packed arrays.
- One natural sub-module: cm_sort_rank.
  - Parameters: DCNT, DWIDTH, POS.
  - Computes the rank of element POS given the full vector.
  - cm_sort instantiates it DCNT times in a generate loop.

Test Plan:
1. Reset: hold i_rst 2 cycles with i_vld=1, i_data random → o_vld=0, o_data=0, o_idx=0 throughout and 1 cycle after release.
2. DCNT=4, REG_CNT=1, i_data=[30,10,40,20] (index 0..3) → one cycle later o_vld=1, o_data=[10,20,30,40], o_idx=[1,3,0,2]; next cycle o_vld=0 with data held.
3. Duplicates, DCNT=6, i_data=[FFFF,5,FFFF,7,FFFF,1] → o_data=[1,5,7,FFFF,FFFF,FFFF], o_idx=[5,1,3,0,2,4].
4. DCNT=10, REG_CNT=4, vectors A and B on consecutive cycles → sorted A and sorted B on consecutive cycles, exactly 4 cycles after each input; o_vld high for 2 cycles.
5. REG_CNT=3, pulse i_vld, assert i_rst 1 cycle later → o_vld never rises and outputs read 0.
6. Random regression over DCNT∈{4,6,8,10}, REG_CNT∈{1..4}, 1000 vectors each, against a bubble-sort reference model → o_data equals the model and o_data[k]==input[o_idx[k]] for all k. Repeat with CM_SORT_DESC_EN defined against a descending model.
